// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between the producers, the round-robin arbiter and the shared FIFO.
// The slave modport is the arbiter's view; master is the producer/FIFO side.
interface fifo_wr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8
);
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    ack;
    logic               fifo_full;
    logic               fifo_wr;
    logic [DW-1:0]      fifo_wdata;
    logic [15:0]        stall_cnt;

    modport slave (
        input  req, req_data, fifo_full,
        output gnt, ack, fifo_wr, fifo_wdata, stall_cnt
    );

    modport master (
        output req, req_data, fifo_full,
        input  gnt, ack, fifo_wr, fifo_wdata, stall_cnt
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers, with bounded
// bursts, FULL throttling and a saturating stall counter.
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int BURST = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    fifo_wr_arbiter_if.slave   bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(BURST + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]      fsm_r;
    logic [IW-1:0]   owner_r;
    logic [CW-1:0]   cnt_r;
    logic [IW-1:0]   rr_ptr_r;
    logic [NREQ-1:0] gnt_r;
    logic [15:0]     stall_cnt_r;

    logic            found_s;
    logic [IW-1:0]   pick_s;
    logic            owner_req_s;
    logic            fifo_wr_s;
    logic            stall_s;
    logic            last_word_s;

    function automatic logic [NREQ-1:0] one_hot(input logic [IW-1:0] idx);
        logic [NREQ-1:0] v;
        v = {NREQ{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    // Pick the first requester at or after rr_ptr (wrapping).
    always_comb begin
        found_s = 1'b0;
        pick_s  = {IW{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (int'(rr_ptr_r) + k) % NREQ;
            if (!found_s && bus.req[idx]) begin
                found_s = 1'b1;
                pick_s  = IW'(idx);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Write qualification for the current owner; FULL gates the write combinationally.
    always_comb begin
        owner_req_s = bus.req[owner_r];
        fifo_wr_s   = (fsm_r == ST_GRANT) && owner_req_s && !bus.fifo_full;
        stall_s     = (fsm_r == ST_GRANT) && owner_req_s && bus.fifo_full;
        last_word_s = (cnt_r == CW'(BURST - 1));
    end

    assign bus.fifo_wr    = fifo_wr_s;
    assign bus.ack        = fifo_wr_s ? one_hot(owner_r) : {NREQ{1'b0}};
    assign bus.fifo_wdata = bus.req_data[int'(owner_r)*DW +: DW];
    assign bus.gnt        = gnt_r;
    assign bus.stall_cnt  = stall_cnt_r;

    // Grant FSM: arbitrate in IDLE, hold ownership until request drops or burst completes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_r    <= ST_IDLE;
            owner_r  <= {IW{1'b0}};
            cnt_r    <= {CW{1'b0}};
            rr_ptr_r <= {IW{1'b0}};
            gnt_r    <= {NREQ{1'b0}};
        end else begin
            case (fsm_r)
                ST_IDLE: begin
                    if (found_s) begin
                        owner_r <= pick_s;
                        gnt_r   <= one_hot(pick_s);
                        cnt_r   <= {CW{1'b0}};
                        fsm_r   <= ST_GRANT;
                    end else begin
                        fsm_r   <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    if (!owner_req_s || (fifo_wr_s && last_word_s)) begin
                        fsm_r    <= ST_IDLE;
                        gnt_r    <= {NREQ{1'b0}};
                        rr_ptr_r <= (owner_r == IW'(NREQ - 1)) ? {IW{1'b0}} : owner_r + IW'(1);
                    end else begin
                        fsm_r    <= ST_GRANT;
                    end
                    if (fifo_wr_s) begin
                        cnt_r <= cnt_r + CW'(1);
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                default: begin
                    fsm_r <= ST_IDLE;
                    gnt_r <= {NREQ{1'b0}};
                end
            endcase
        end
    end

    // Saturating count of cycles where the owner is blocked by FULL.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_r <= 16'h0000;
        end else if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: producer and FIFO models around the DUT, expected
// (owner, data) writes queued at stimulus time and compared on every fifo_wr cycle.
module tb_fifo_wr_arbiter;
    logic clk;
    logic rst_n;

    fifo_wr_arbiter_if #(.NREQ(4), .DW(8)) bus ();

    fifo_wr_arbiter #(.NREQ(4), .DW(8), .BURST(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] src_q [4][$];
    logic [9:0] sb_q [$];
    logic [7:0] fifo_q [$];
    logic [3:0] en;
    int         rd_budget;
    bit         mon_on;

    logic        obs_wr;
    logic [3:0]  obs_ack;
    logic [3:0]  obs_gnt;
    logic [7:0]  obs_wdata;
    logic [15:0] obs_stall;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            bus.req[i] = en[i] && (src_q[i].size() > 0);
            bus.req_data[i*8 +: 8] = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
        end
        bus.fifo_full = (fifo_q.size() >= 16);
    endtask

    task automatic expect_wr(input int owner, input logic [7:0] data);
        logic [1:0] o;
        o = 2'(owner);
        sb_q.push_back({o, data});
    endtask

    task automatic cycle();
        logic [9:0] e;
        logic [3:0] hot;
        drive();
        @(negedge clk);
        obs_wr    = bus.fifo_wr;
        obs_ack   = bus.ack;
        obs_gnt   = bus.gnt;
        obs_wdata = bus.fifo_wdata;
        obs_stall = bus.stall_cnt;
        if (mon_on) begin
            if (obs_wr === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk_eq("unexp_wr", 32'(obs_wr), 32'(0));
                end else begin
                    e   = sb_q.pop_front();
                    hot = 4'b0001 << e[9:8];
                    chk_eq("wr_ack", 32'(obs_ack), 32'(hot));
                    chk_eq("wr_gnt", 32'(obs_gnt), 32'(hot));
                    chk_eq("wr_data", 32'(obs_wdata), 32'(e[7:0]));
                end
                chk_eq("overflow", 32'(fifo_q.size() >= 16), 32'(0));
            end else begin
                chk_eq("ack_idle", 32'(obs_ack), 32'(0));
            end
        end
        @(posedge clk);
        #1;
        if (rd_budget > 0 && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            rd_budget--;
        end
        if (obs_wr === 1'b1) begin
            fifo_q.push_back(obs_wdata);
            for (int i = 0; i < 4; i++) begin
                if (obs_ack[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            end
        end
    endtask

    task automatic run_until_empty(output int n);
        n = 0;
        while (sb_q.size() > 0 && n < 300) begin
            cycle();
            n++;
        end
        if (sb_q.size() != 0) chk_eq("timeout_sb", 32'(sb_q.size()), 32'(0));
    endtask

    task automatic settle();
        en = 4'b0000;
        repeat (2) cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0;
        en = 4'b0000;
        mon_on = 1'b0;
        rd_budget = 0;
        bus.req = 4'b0000;
        bus.req_data = 32'h0;
        bus.fifo_full = 1'b0;

        // Reset with all requesters active, then full contention.
        cycle();
        mon_on = 1'b1;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 8; j++) src_q[i].push_back(8'(8'h80 | (i << 4) | j));
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) expect_wr(i, 8'(8'h80 | (i << 4) | (r*4 + j)));
        en = 4'b1111;
        rd_budget = 100000;
        for (int k = 0; k < 2; k++) begin
            cycle();
            chk_eq("rst_gnt", 32'(obs_gnt), 32'(0));
            chk_eq("rst_ack", 32'(obs_ack), 32'(0));
            chk_eq("rst_wr", 32'(obs_wr), 32'(0));
            chk_eq("rst_stall", 32'(obs_stall), 32'(0));
            chk_eq("rst_wdata", 32'(obs_wdata), 32'(8'h80));
        end
        rst_n = 1'b1;
        run_until_empty(n);
        chk_eq("cont_cycles", 32'(n), 32'(40));
        settle();

        // Single requester, three words.
        src_q[2] = '{8'h11, 8'h12, 8'h13};
        expect_wr(2, 8'h11); expect_wr(2, 8'h12); expect_wr(2, 8'h13);
        en = 4'b0100;
        run_until_empty(n);
        chk_eq("single_cycles", 32'(n), 32'(4));
        settle();
        src_q[0] = '{8'h01}; src_q[1] = '{8'h0A}; src_q[3] = '{8'h31};
        expect_wr(3, 8'h31); expect_wr(0, 8'h01); expect_wr(1, 8'h0A);
        en = 4'b1011;
        run_until_empty(n);
        settle();

        // FULL stall with requester 1.
        fifo_q.delete();
        rd_budget = 0;
        for (int k = 0; k < 16; k++) fifo_q.push_back(8'hEE);
        src_q[1] = '{8'h51, 8'h52, 8'h53};
        expect_wr(1, 8'h51); expect_wr(1, 8'h52); expect_wr(1, 8'h53);
        en = 4'b0010;
        cycle();
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk_eq("stall_wr", 32'(obs_wr), 32'(0));
            chk_eq("stall_gnt", 32'(obs_gnt), 32'(4'b0010));
            chk_eq("stall_cnt", 32'(obs_stall), 32'(k));
        end
        rd_budget = 1;
        cycle();
        cycle();
        chk_eq("resume_wr", 32'(obs_wr), 32'(1));
        rd_budget = 100000;
        run_until_empty(n);
        settle();
        chk_eq("stall_total", 32'(obs_stall), 32'(7));

        // Mid-burst release by requester 0 after two words.
        fifo_q.delete();
        rd_budget = 0;
        src_q[0] = '{8'h61, 8'h62};
        expect_wr(0, 8'h61); expect_wr(0, 8'h62);
        en = 4'b0001;
        repeat (3) cycle();
        cycle();
        chk_eq("rel_gnt_hold", 32'(obs_gnt), 32'(4'b0001));
        chk_eq("rel_wr", 32'(obs_wr), 32'(0));
        cycle();
        chk_eq("rel_gnt_off", 32'(obs_gnt), 32'(0));
        chk_eq("rel_fifo_words", 32'(fifo_q.size()), 32'(2));
        rd_budget = 100000;
        src_q[0] = '{8'h63}; src_q[1] = '{8'h71};
        expect_wr(1, 8'h71); expect_wr(0, 8'h63);
        en = 4'b0011;
        run_until_empty(n);
        settle();

        // Reset in the middle of a burst from requester 2.
        src_q[2] = '{8'h91, 8'h92, 8'h93, 8'h94};
        expect_wr(2, 8'h91); expect_wr(2, 8'h92);
        en = 4'b0100;
        cycle();
        cycle();
        rst_n = 1'b0;
        cycle();
        for (int k = 0; k < 2; k++) begin
            cycle();
            chk_eq("mrst_gnt", 32'(obs_gnt), 32'(0));
            chk_eq("mrst_wr", 32'(obs_wr), 32'(0));
            chk_eq("mrst_stall", 32'(obs_stall), 32'(0));
        end
        rst_n = 1'b1;
        src_q[0] = '{8'hA1};
        expect_wr(0, 8'hA1); expect_wr(2, 8'h93); expect_wr(2, 8'h94);
        en = 4'b0101;
        run_until_empty(n);
        settle();
        chk_eq("sb_left", 32'(sb_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single 8-bit synchronous FIFO (16 entries) among NREQ producers. It grants the FIFO write port to one requester at a time for a bounded burst, throttles writes on FULL so the FIFO never overflows, and counts stall cycles. It sits between the producer blocks and the FIFO's wr / WRITE_DATA / FULL pins.

## Interface
- NREQ, 4: number of requesters (2..8)
- DW, 8: data width; must equal the FIFO write width
- BURST, 4: maximum words accepted per grant (1..16)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; synchronous, active-low
- req  in  NREQ  per-requester write request; held high while the requester has a valid word
- req_data  in  NREQ*DW  flattened data; slice i is bits [i*DW +: DW], stable while req[i]=1
- gnt  out  NREQ  registered one-hot grant; all zero when idle
- ack  out  NREQ  combinational one-hot; ack[i]=1 means req_data slice i is written this cycle
- fifo_full  in  1  FULL from the FIFO
- fifo_wr  out  1  FIFO write enable (combinational)
- fifo_wdata  out  DW  FIFO write data (combinational mux of the owner's slice)
- stall_cnt  out  16  saturating count of cycles with a grant held, req high, and fifo_full=1

## Operation
- Registered state: fsm (IDLE, GRANT), owner index, burst count cnt (width covers BURST), round-robin pointer rr_ptr, gnt, stall_cnt.
- IDLE: if any req bit is set, select the first set index scanning rr_ptr, rr_ptr+1, ... modulo NREQ; owner <= that index, gnt <= one-hot(owner), cnt <= 0, go to GRANT. Otherwise stay in IDLE.
- GRANT write condition: fifo_wr = (fsm==GRANT) & req[owner] & ~fifo_full. ack = fifo_wr ? one-hot(owner) : 0. fifo_wdata = slice owner, regardless of fifo_wr.
- Each write increments cnt.
- Exit GRANT to IDLE when either:
  - req[owner]=0; or
  - a write occurs with cnt==BURST-1.
- On exit: gnt <= 0; rr_ptr <= (owner+1) mod NREQ.
- Stall: in GRANT with req[owner]=1 and fifo_full=1, there is no write and no cnt change; the grant is held indefinitely. stall_cnt increments, saturating at 16'hFFFF.
- Non-owner req bits never produce writes. Requests raised during GRANT wait for the next IDLE arbitration.
- Reset (rst_n=0 at a rising edge), including mid-burst: fsm=IDLE, owner=0, cnt=0, rr_ptr=0, gnt=0, stall_cnt=0. ack and fifo_wr are 0 because fsm=IDLE. A word not yet acked is not written.

## Timing
- Arbitration latency: gnt is asserted on the first edge after req is seen in IDLE. The first write can occur in that same GRANT cycle.
- Throughput: one word per cycle within a burst. Exactly one idle bubble cycle between grants.
- Handshake: a requester advances its data on the edge where ack[i]=1. It may drop req at any time; a drop ends the grant at the next edge.
- FULL: fifo_wr is gated combinationally by fifo_full, so the FIFO OVERFLOW flag must never assert. Writes resume in the first cycle fifo_full=0.
- Simultaneous requests: the bit nearest rr_ptr wins; every requester is served within NREQ grants.
- Reset values: gnt=0, ack=0, fifo_wr=0, stall_cnt=0. fifo_wdata equals req_data slice 0.

## Test plan
- Reset: hold rst_n=0 for 2 edges with req=4'b1111 -> gnt=0, ack=0, fifo_wr=0, stall_cnt=0; after release, the first grant is gnt=4'b0001.
- Single requester: req[2] with 3 words 0x11,0x12,0x13, BURST=4 -> gnt=4'b0100 one edge after req; 3 consecutive acks; FIFO reads back 0x11,0x12,0x13; the next grant starts scanning at index 3.
- Full contention: req=4'b1111 continuously, each requester sending a distinct data pattern, FIFO drained -> grant order 0,1,2,3,0; 4 writes per grant; 1 bubble between grants; FIFO read order matches.
- FULL stall: write 16 words so FULL=1, with req[1] still high -> fifo_wr=0, ack=0, stall_cnt increments each cycle; after one FIFO read, the write resumes the same cycle FULL drops; OVERFLOW stays 0.
- Mid-burst release: req[0] drops after 2 of 4 words -> grant ends next edge; exactly 2 words in the FIFO; rr_ptr=1.
- Reset mid-burst: assert rst_n=0 after the 2nd word of a burst -> gnt=0 next edge; no further writes; arbitration restarts from index 0.
